// File: rtl/ifetch_if.sv
// ============================================================================
// ifetch_if : instruction read bus, decoder handshake and redirect bundle
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface ifetch_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
);
  logic                  ir_addr_valid;
  logic                  ir_addr_ready;
  logic [PC_WIDTH-1:0]   ir_addr;
  logic                  ir_data_valid;
  logic                  ir_data_ready;
  logic [INST_WIDTH-1:0] ir_data;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [INST_WIDTH-1:0] inst;
  logic [PC_WIDTH-1:0]   inst_pc;
  logic                  pc_load;
  logic [PC_WIDTH-1:0]   pc_next;

  modport master (
    output ir_addr_valid, ir_addr, ir_data_ready, inst_valid, inst, inst_pc,
    input  ir_addr_ready, ir_data_valid, ir_data, inst_ready, pc_load, pc_next
  );

  modport slave (
    input  ir_addr_valid, ir_addr, ir_data_ready, inst_valid, inst, inst_pc,
    output ir_addr_ready, ir_data_valid, ir_data, inst_ready, pc_load, pc_next
  );
endinterface

`default_nettype wire

// File: rtl/ifetch.sv
// ============================================================================
// ifetch : PC register and single-outstanding instruction fetch stage
// Revision  : 1.0
// ============================================================================
`default_nettype none

module ifetch #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic clk,
  input  logic rst,
  ifetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  discard_q, discard_d;
  logic [PC_WIDTH-1:0]   pc_target;

  assign pc_target = bus.pc_next & ~PC_WIDTH'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_ADDR;
      inst_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    discard_d = discard_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.ir_addr_ready) state_d = WAIT;
        if (bus.pc_load) begin
          pc_d = pc_target;
          // Read already issued to the old PC: its data must be dropped
          if (bus.ir_addr_ready) discard_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.ir_data_valid) begin
          state_d   = REQ;
          discard_d = 1'b0;
          if (bus.pc_load) begin
            pc_d = pc_target;
          end else if (!discard_q) begin
            inst_d  = bus.ir_data;
            state_d = HOLD;
          end
        end else if (bus.pc_load) begin
          pc_d      = pc_target;
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.pc_load) begin
          pc_d    = pc_target;
          state_d = REQ;
        end else if (bus.inst_ready) begin
          pc_d    = pc_q + PC_WIDTH'(4);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ir_addr_valid = (state_q == REQ);
  assign bus.ir_data_ready = (state_q == WAIT);
  assign bus.inst_valid    = (state_q == HOLD);
  assign bus.ir_addr       = pc_q;
  assign bus.inst_pc       = pc_q;
  assign bus.inst          = inst_q;

endmodule

`default_nettype wire
